ptw_mem_arbiter: RTL and testbench
==================================

# ptw_mem_arbiter

Shares one memory read port between the page-table walkers of the instruction-side MMU (in `ifu`) and the data-side MMU (in the LSU). It is a single-outstanding, round-robin arbiter with a three-state sequencer. It captures the winner's PTE address, drives the downstream valid/ready request, and steers the returned PTE word back to the owner. A flush discards the owner's in-flight response without breaking the downstream handshake.

## Interface
Parameters:
- ADDR_W, 32, PTE address width (SV32 physical)
- DATA_W, 32, PTE data width

Ports:
- clk  in  1  clock; all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- ifu_mem_req_i  in  1  IFU-MMU walk request, level; held until its rvalid
- ifu_mem_addr_i  in  ADDR_W  IFU PTE address; stable while req high
- ifu_mem_rdata_o  out  DATA_W  PTE data to IFU-MMU
- ifu_mem_rvalid_o  out  1  one-cycle PTE valid to IFU-MMU
- ifu_flush_i  in  1  IFU-MMU flush (mmu_flush / if_flush)
- lsu_mem_req_i, lsu_mem_addr_i, lsu_mem_rdata_o, lsu_mem_rvalid_o, lsu_flush_i  same as the IFU ports, for the LSU-MMU
- mem_req_valid_o  out  1  downstream read request valid
- mem_req_addr_o  out  ADDR_W  downstream read address
- mem_req_ready_i  in  1  downstream accepts the request
- mem_rvalid_i  in  1  downstream read data valid
- mem_rdata_i  in  DATA_W  downstream read data
- busy_o  out  1  state != IDLE
- owner_o  out  1  current or last owner: 0 = IFU, 1 = LSU

## Operation
- States:
  - IDLE: no transaction.
  - ADDR: mem_req_valid_o=1, waiting for ready.
  - DATA: waiting for mem_rvalid_i.
- Effective requests: eff_ifu = ifu_mem_req_i & ~ifu_flush_i; likewise eff_lsu.
- IDLE with any effective request → ADDR.
  - A single requester wins.
  - If both request, the one not equal to rr_last wins.
  - On grant: register the winner's address into addr_q, owner ← winner, rr_last ← winner, drop ← 0.
- ADDR: mem_req_valid_o=1, mem_req_addr_o=addr_q. On mem_req_ready_i → DATA.
- DATA: on mem_rvalid_i → IDLE.
  - If drop=0 and the owner's flush is low that cycle: owner rvalid_o=1, rdata_o = mem_rdata_i (combinational pass-through).
- Flush:
  - An owner flush in ADDR or DATA sets drop=1.
  - The request still completes downstream. mem_req_valid_o is never withdrawn before ready.
  - The response is consumed but not forwarded.
  - A flush on the non-owner only masks that requester in IDLE.
- rdata_o for both requesters is always mem_rdata_i. Only the rvalids are steered.
- mem_rvalid_i in IDLE or ADDR is ignored. This covers responses that straddle a reset.
- mem_req_addr_o = addr_q in all states.

## Timing
- Reset values: state=IDLE, mem_req_valid_o=0, addr_q=0, owner_o=0, rr_last=1 (IFU wins the first tie), drop=0, busy_o=0. Both rvalid_o are 0.
- Grant latency: a request seen in IDLE at cycle T gives mem_req_valid_o=1 at T+1 (registered).
- Minimum transaction: IDLE(T) → ADDR(T+1, ready=1) → DATA(T+2, rvalid=1) → IDLE(T+3). That is 3 cycles of occupancy.
- Response latency: the owner's rvalid_o comes in the same cycle as mem_rvalid_i (zero added latency).
- Requester side:
  - Requesters drop req the cycle after their rvalid.
  - The arbiter is back in IDLE that cycle, so a stale req is not re-granted.
  - Back-to-back grants alternate when both requesters keep requesting.
- Simultaneous events:
  - Owner flush in the same cycle as mem_rvalid_i suppresses rvalid_o.
  - A flush and a new request from the same requester in IDLE: no grant.
- Reset mid-transaction: reset is asynchronous and goes straight to IDLE. The downstream side must also be reset, because a pending downstream response is ignored.
- No combinational path from the req inputs to the mem_* outputs.

## Test plan
- Single IFU request, addr=0x8000_1004, ready immediate, rvalid 3 cycles later with rdata=0x2000_00CF → mem_req_valid high exactly 1 cycle with that address; ifu_mem_rvalid_o pulses once with 0x2000_00CF; lsu_mem_rvalid_o stays 0.
- IFU and LSU request in the same cycle after reset → IFU granted first, LSU second. Under continuous requests the grants alternate IFU, LSU, IFU.
- ready held low 5 cycles → mem_req_valid_o and mem_req_addr_o stay stable for all 5 cycles; DATA is entered only on ready.
- LSU owner, lsu_flush_i pulsed in DATA before rvalid → rvalid consumed, lsu_mem_rvalid_o stays 0, FSM returns to IDLE, and a pending IFU request is granted next.
- Assert rst_n low while in DATA, release it, then inject a stray mem_rvalid_i → all outputs at reset values, no rvalid forwarded, busy_o=0.
- Both requesting while ifu_flush_i=1 in IDLE → LSU granted regardless of rr_last.

Source files
------------

// File: rtl/ptw_mem_arbiter_if.sv
// Bus bundle between the two MMU page-table walkers, the PTW memory arbiter and the downstream read port.
// The arbiter uses the slave modport; the environment around it uses the master modport.
interface ptw_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_mem_req_i;
  logic [ADDR_W-1:0] ifu_mem_addr_i;
  logic [DATA_W-1:0] ifu_mem_rdata_o;
  logic              ifu_mem_rvalid_o;
  logic              ifu_flush_i;

  logic              lsu_mem_req_i;
  logic [ADDR_W-1:0] lsu_mem_addr_i;
  logic [DATA_W-1:0] lsu_mem_rdata_o;
  logic              lsu_mem_rvalid_o;
  logic              lsu_flush_i;

  logic              mem_req_valid_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_req_ready_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              busy_o;
  logic              owner_o;

  modport slave (
    input  ifu_mem_req_i, ifu_mem_addr_i, ifu_flush_i,
    input  lsu_mem_req_i, lsu_mem_addr_i, lsu_flush_i,
    input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    output ifu_mem_rdata_o, ifu_mem_rvalid_o,
    output lsu_mem_rdata_o, lsu_mem_rvalid_o,
    output mem_req_valid_o, mem_req_addr_o,
    output busy_o, owner_o
  );

  modport master (
    output ifu_mem_req_i, ifu_mem_addr_i, ifu_flush_i,
    output lsu_mem_req_i, lsu_mem_addr_i, lsu_flush_i,
    output mem_req_ready_i, mem_rvalid_i, mem_rdata_i,
    input  ifu_mem_rdata_o, ifu_mem_rvalid_o,
    input  lsu_mem_rdata_o, lsu_mem_rvalid_o,
    input  mem_req_valid_o, mem_req_addr_o,
    input  busy_o, owner_o
  );
endinterface

// File: rtl/ptw_mem_arbiter.sv
// Single-outstanding round-robin arbiter sharing one PTE read port between the IFU and LSU page-table walkers.
// state  | meaning
// IDLE   | no transaction; arbitrate effective requests
// ADDR   | downstream request valid, waiting for ready
// DATA   | request accepted, waiting for read data
module ptw_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  ptw_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic              drop_q, drop_d;

  logic              eff_ifu, eff_lsu;
  logic              winner;
  logic              owner_flush;
  logic              fwd;
  logic [DATA_W-1:0] rdata;

  assign eff_ifu     = bus.ifu_mem_req_i & ~bus.ifu_flush_i;
  assign eff_lsu     = bus.lsu_mem_req_i & ~bus.lsu_flush_i;
  // On a tie the requester that did not win last time goes next.
  assign winner      = (eff_ifu & eff_lsu) ? ~rr_last_q : eff_lsu;
  assign owner_flush = owner_q ? bus.lsu_flush_i : bus.ifu_flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    drop_d    = drop_q;
    fwd       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eff_ifu | eff_lsu) begin
          state_d   = S_ADDR;
          addr_d    = winner ? bus.lsu_mem_addr_i : bus.ifu_mem_addr_i;
          owner_d   = winner;
          rr_last_d = winner;
          drop_d    = 1'b0;
        end
      end
      S_ADDR: begin
        // A flush never withdraws the request; it only marks the response for discard.
        if (owner_flush) drop_d = 1'b1;
        if (bus.mem_req_ready_i) state_d = S_DATA;
      end
      S_DATA: begin
        if (owner_flush) drop_d = 1'b1;
        if (bus.mem_rvalid_i) begin
          state_d = S_IDLE;
          fwd     = ~drop_q & ~owner_flush;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata                = bus.mem_rdata_i;
  assign bus.ifu_mem_rdata_o  = rdata;
  assign bus.lsu_mem_rdata_o  = rdata;
  assign bus.ifu_mem_rvalid_o = fwd & ~owner_q;
  assign bus.lsu_mem_rvalid_o = fwd & owner_q;
  assign bus.mem_req_valid_o  = (state_q == S_ADDR);
  assign bus.mem_req_addr_o   = addr_q;
  assign bus.busy_o           = (state_q != S_IDLE);
  assign bus.owner_o          = owner_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Bench for ptw_mem_arbiter: directed scenarios plus a randomized transaction-level run
// checked against a round-robin reference model.
module tb_ptw_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ptw_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ptw_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_mem_req_i   = 1'b0;
    bus.ifu_mem_addr_i  = '0;
    bus.ifu_flush_i     = 1'b0;
    bus.lsu_mem_req_i   = 1'b0;
    bus.lsu_mem_addr_i  = '0;
    bus.lsu_flush_i     = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rvalid_i    = 1'b0;
    bus.mem_rdata_i     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({bus.mem_req_valid_o, bus.busy_o, bus.owner_o, bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b exp 00000", {bus.mem_req_valid_o, bus.busy_o, bus.owner_o, bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o});
    end
    n_cmp++;
    if (bus.mem_req_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_addr got %h exp 00000000", bus.mem_req_addr_o);
    end
    do_reset();
  endtask

  task automatic test_single_ifu();
    int valid_cycles;
    do_reset();
    bus.ifu_mem_req_i  = 1'b1;
    bus.ifu_mem_addr_i = 32'h8000_1004;
    valid_cycles = 0;
    n_cmp++;
    if (bus.mem_req_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_no_comb_valid got %b exp 0", bus.mem_req_valid_o);
    end
    tick();
    if (bus.mem_req_valid_o === 1'b1) valid_cycles++;
    n_cmp++;
    if (bus.mem_req_addr_o !== 32'h8000_1004 || bus.owner_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_addr got %h/%b exp 80001004/0", bus.mem_req_addr_o, bus.owner_o);
    end
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_req_valid_o === 1'b1) valid_cycles++;
      if (i == 2) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h2000_00CF;
        #1;
        n_cmp++;
        if (bus.ifu_mem_rvalid_o !== 1'b1 || bus.ifu_mem_rdata_o !== 32'h2000_00CF || bus.lsu_mem_rvalid_o !== 1'b0) begin
          n_err++;
          $display("FAIL single_resp got %b/%h/%b exp 1/200000cf/0", bus.ifu_mem_rvalid_o, bus.ifu_mem_rdata_o, bus.lsu_mem_rvalid_o);
        end
      end else begin
        n_cmp++;
        if (bus.ifu_mem_rvalid_o !== 1'b0 || bus.lsu_mem_rvalid_o !== 1'b0) begin
          n_err++;
          $display("FAIL single_early_rvalid got %b%b exp 00", bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o);
        end
      end
      tick();
    end
    bus.mem_rvalid_i  = 1'b0;
    bus.ifu_mem_req_i = 1'b0;
    #1;
    n_cmp++;
    if (valid_cycles != 1 || bus.busy_o !== 1'b0 || bus.ifu_mem_rvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_end got valid_cycles=%0d busy=%b exp 1/0", valid_cycles, bus.busy_o);
    end
  endtask

  task automatic test_tie_alternate();
    logic exp_own [3];
    exp_own[0] = 1'b0;
    exp_own[1] = 1'b1;
    exp_own[2] = 1'b0;
    do_reset();
    bus.ifu_mem_req_i  = 1'b1;
    bus.ifu_mem_addr_i = 32'h0000_1110;
    bus.lsu_mem_req_i  = 1'b1;
    bus.lsu_mem_addr_i = 32'h0000_2220;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (bus.owner_o !== exp_own[k] || bus.mem_req_valid_o !== 1'b1 ||
          bus.mem_req_addr_o !== (exp_own[k] ? 32'h0000_2220 : 32'h0000_1110)) begin
        n_err++;
        $display("FAIL tie_grant%0d got owner=%b addr=%h exp owner=%b", k, bus.owner_o, bus.mem_req_addr_o, exp_own[k]);
      end
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rvalid_i    = 1'b1;
      bus.mem_rdata_i     = 32'hA000_0000 + 32'(k);
      #1;
      n_cmp++;
      if (bus.ifu_mem_rvalid_o !== ~exp_own[k] || bus.lsu_mem_rvalid_o !== exp_own[k]) begin
        n_err++;
        $display("FAIL tie_resp%0d got ifu=%b lsu=%b exp owner=%b", k, bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o, exp_own[k]);
      end
      tick();
      bus.mem_rvalid_i = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_ready_stall();
    do_reset();
    bus.lsu_mem_req_i  = 1'b1;
    bus.lsu_mem_addr_i = 32'h8123_4568;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 32'h8123_4568) begin
        n_err++;
        $display("FAIL stall_hold%0d got %b/%h exp 1/81234568", i, bus.mem_req_valid_o, bus.mem_req_addr_o);
      end
      tick();
    end
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    n_cmp++;
    if (bus.mem_req_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL stall_data got valid=%b busy=%b exp 0/1", bus.mem_req_valid_o, bus.busy_o);
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0BAD_F00D;
    #1;
    n_cmp++;
    if (bus.lsu_mem_rvalid_o !== 1'b1 || bus.lsu_mem_rdata_o !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL stall_resp got %b/%h exp 1/0badf00d", bus.lsu_mem_rvalid_o, bus.lsu_mem_rdata_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_lsu_flush();
    do_reset();
    bus.lsu_mem_req_i  = 1'b1;
    bus.lsu_mem_addr_i = 32'h0000_4440;
    tick();
    bus.ifu_mem_req_i   = 1'b1;
    bus.ifu_mem_addr_i  = 32'h0000_3330;
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    bus.lsu_flush_i     = 1'b1;
    bus.lsu_mem_req_i   = 1'b0;
    tick();
    bus.lsu_flush_i  = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1234_5678;
    #1;
    n_cmp++;
    if (bus.lsu_mem_rvalid_o !== 1'b0 || bus.ifu_mem_rvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_suppress got lsu=%b ifu=%b exp 0/0", bus.lsu_mem_rvalid_o, bus.ifu_mem_rvalid_o);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle got busy=%b exp 0", bus.busy_o);
    end
    tick();
    n_cmp++;
    if (bus.owner_o !== 1'b0 || bus.mem_req_addr_o !== 32'h0000_3330 || bus.mem_req_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_next_grant got owner=%b addr=%h exp 0/00003330", bus.owner_o, bus.mem_req_addr_o);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.lsu_mem_req_i  = 1'b1;
    bus.lsu_mem_addr_i = 32'h0000_5550;
    tick();
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_req_valid_o, bus.busy_o, bus.owner_o} !== 3'b0 || bus.mem_req_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_values got %b%b%b addr=%h exp 000/0", bus.mem_req_valid_o, bus.busy_o, bus.owner_o, bus.mem_req_addr_o);
    end
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o, bus.busy_o, bus.mem_req_valid_o} !== 4'b0) begin
      n_err++;
      $display("FAIL midrst_stray got %b%b%b%b exp 0000", bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o, bus.busy_o, bus.mem_req_valid_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_flush_mask();
    do_reset();
    bus.ifu_mem_req_i  = 1'b1;
    bus.ifu_mem_addr_i = 32'h0000_6660;
    bus.ifu_flush_i    = 1'b1;
    bus.lsu_mem_req_i  = 1'b1;
    bus.lsu_mem_addr_i = 32'h0000_7770;
    tick();
    bus.ifu_flush_i   = 1'b0;
    bus.ifu_mem_req_i = 1'b0;
    n_cmp++;
    if (bus.owner_o !== 1'b1 || bus.mem_req_addr_o !== 32'h0000_7770 || bus.mem_req_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL mask_grant got owner=%b addr=%h exp 1/00007770", bus.owner_o, bus.mem_req_addr_o);
    end
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rvalid_i    = 1'b1;
    #1;
    n_cmp++;
    if (bus.lsu_mem_rvalid_o !== 1'b1 || bus.ifu_mem_rvalid_o !== 1'b0) begin
      n_err++;
      $display("FAIL mask_resp got lsu=%b ifu=%b exp 1/0", bus.lsu_mem_rvalid_o, bus.ifu_mem_rvalid_o);
    end
    tick();
    clear_inputs();
  endtask

  // Transaction-level model: each round grants one walk; ties go to the requester that did not win last.
  task automatic test_random();
    logic [31:0] a_ifu, a_lsu, exp_addr, rd;
    bit p_ifu, p_lsu, win, last, flush;
    int d_rdy, d_rsp, f_at;
    do_reset();
    last  = 1'b1;
    p_ifu = 1'b0;
    p_lsu = 1'b0;
    a_ifu = '0;
    a_lsu = '0;
    for (int t = 0; t < 60; t++) begin
      if (!p_ifu && $urandom_range(0, 1) == 1) begin
        p_ifu = 1'b1;
        a_ifu = $urandom;
      end
      if (!p_lsu && $urandom_range(0, 1) == 1) begin
        p_lsu = 1'b1;
        a_lsu = $urandom;
      end
      if (!p_ifu && !p_lsu) begin
        p_ifu = 1'b1;
        a_ifu = $urandom;
      end
      bus.ifu_mem_req_i  = p_ifu;
      bus.ifu_mem_addr_i = a_ifu;
      bus.lsu_mem_req_i  = p_lsu;
      bus.lsu_mem_addr_i = a_lsu;
      win      = (p_ifu && p_lsu) ? ~last : p_lsu;
      exp_addr = win ? a_lsu : a_ifu;
      tick();
      n_cmp++;
      if (bus.mem_req_valid_o !== 1'b1 || bus.owner_o !== win || bus.mem_req_addr_o !== exp_addr) begin
        n_err++;
        $display("FAIL rnd_grant%0d got v=%b owner=%b addr=%h exp 1/%b/%h", t, bus.mem_req_valid_o, bus.owner_o, bus.mem_req_addr_o, win, exp_addr);
      end
      d_rdy = $urandom_range(0, 3);
      for (int i = 0; i < d_rdy; i++) begin
        bus.mem_rvalid_i = ($urandom_range(0, 1) == 1);
        #1;
        n_cmp++;
        if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== exp_addr ||
            bus.ifu_mem_rvalid_o !== 1'b0 || bus.lsu_mem_rvalid_o !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_wait%0d got v=%b addr=%h rv=%b%b exp 1/%h/00", t, bus.mem_req_valid_o, bus.mem_req_addr_o, bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o, exp_addr);
        end
        tick();
      end
      bus.mem_rvalid_i    = 1'b0;
      bus.mem_req_ready_i = 1'b1;
      tick();
      bus.mem_req_ready_i = 1'b0;
      flush = ($urandom_range(0, 3) == 0);
      d_rsp = $urandom_range(0, 3);
      f_at  = $urandom_range(0, d_rsp);
      for (int i = 0; i <= d_rsp; i++) begin
        if (flush && i == f_at) begin
          if (win) begin
            bus.lsu_flush_i   = 1'b1;
            bus.lsu_mem_req_i = 1'b0;
            p_lsu = 1'b0;
          end else begin
            bus.ifu_flush_i   = 1'b1;
            bus.ifu_mem_req_i = 1'b0;
            p_ifu = 1'b0;
          end
        end else begin
          bus.ifu_flush_i = 1'b0;
          bus.lsu_flush_i = 1'b0;
        end
        rd               = $urandom;
        bus.mem_rdata_i  = rd;
        bus.mem_rvalid_i = (i == d_rsp);
        #1;
        n_cmp++;
        if (i == d_rsp) begin
          if (bus.ifu_mem_rvalid_o !== (!flush && !win) || bus.lsu_mem_rvalid_o !== (!flush && win) ||
              bus.ifu_mem_rdata_o !== rd || bus.lsu_mem_rdata_o !== rd) begin
            n_err++;
            $display("FAIL rnd_resp%0d got rv=%b%b data=%h exp flush=%b owner=%b data=%h", t, bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o, bus.ifu_mem_rdata_o, flush, win, rd);
          end
        end else if (bus.ifu_mem_rvalid_o !== 1'b0 || bus.lsu_mem_rvalid_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_data%0d got rv=%b%b v=%b exp 00/0", t, bus.ifu_mem_rvalid_o, bus.lsu_mem_rvalid_o, bus.mem_req_valid_o);
        end
        tick();
      end
      bus.mem_rvalid_i = 1'b0;
      bus.ifu_flush_i  = 1'b0;
      bus.lsu_flush_i  = 1'b0;
      if (win) p_lsu = 1'b0;
      else     p_ifu = 1'b0;
      bus.ifu_mem_req_i = p_ifu;
      bus.lsu_mem_req_i = p_lsu;
      last = win;
      n_cmp++;
      if (bus.busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_idle%0d got busy=%b exp 0", t, bus.busy_o);
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_ifu();
    test_tie_alternate();
    test_ready_stall();
    test_lsu_flush();
    test_reset_mid();
    test_flush_mask();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
